lane_serializer: RTL and testbench

//  Per-lane parallel-to-serial stage; sits directly downstream of the byte-striping

---
 rtl/lane_serializer.sv | 76 +++++++
 tb/tb_lane_serializer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lane_serializer.sv
// lane_serializer: MSB-first word serializer with idle framing; define SER_WORD_CNT_EN to add the words_sent counter
module lane_serializer #(
    parameter int         WIDTH       = 32,
    parameter logic [7:0] IDLE_BYTE   = 8'hBC,
    parameter int         INIT_FRAMES = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             frame_start,
    output logic             is_data
`ifdef SER_WORD_CNT_EN
    ,
    output logic [15:0]      words_sent
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam int FW = $clog2(INIT_FRAMES + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [FW-1:0] LAST_INIT = FW'(INIT_FRAMES - 1);
    localparam logic [WIDTH-1:0] IDLE_WORD = {(WIDTH/8){IDLE_BYTE}};
    typedef enum logic {INIT, ACTIVE} state_t;
    state_t state, state_next;
    logic [CW-1:0] bit_cnt;
    logic [FW-1:0] frame_cnt;
    logic [WIDTH-1:0] hold, shifter, word;
    logic hold_full, load, accept;
    assign load = bit_cnt == '0;
    assign ready_out = (state == ACTIVE) && !hold_full;
    assign accept = valid_in && ready_out;
    // a word accepted on a load edge is not yet in hold, so that frame goes out idle
    assign word = hold_full ? hold : IDLE_WORD;
    always_comb state_next = (state == INIT && load && frame_cnt == LAST_INIT) ? ACTIVE : state;
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state <= INIT;
            bit_cnt <= '0;
            frame_cnt <= '0;
            shifter <= '0;
            hold_full <= 1'b0;
            data_out <= 1'b0;
            frame_start <= 1'b0;
            is_data <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                data_out <= word[WIDTH-1];
                shifter <= word << 1;
                bit_cnt <= 1;
                frame_start <= 1'b1;
                is_data <= hold_full;
                if (state == INIT) frame_cnt <= frame_cnt + 1'b1;
            end else begin
                data_out <= shifter[WIDTH-1];
                shifter <= shifter << 1;
                frame_start <= 1'b0;
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
            if (accept) begin
                hold <= data_in;
                hold_full <= 1'b1;
            end else if (load && hold_full) begin
                hold_full <= 1'b0;
            end
        end
    end
`ifdef SER_WORD_CNT_EN
    always_ff @(posedge clk_32f) begin
        if (reset) words_sent <= '0;
        else if (load && hold_full && words_sent != 16'hFFFF) words_sent <= words_sent + 1'b1;
    end
`endif
endmodule

// File: tb/tb_lane_serializer.sv
// tb_lane_serializer: directed bench with a time-indexed frame model for lane_serializer
module tb_lane_serializer;
    localparam int W = 32;
    localparam logic [31:0] IDLE = 32'hBCBCBCBC;
    logic clk_32f = 0, reset = 1, valid_in = 0;
    logic [31:0] data_in = 0;
    logic ready_out, data_out, frame_start, is_data;
`ifdef SER_WORD_CNT_EN
    logic [15:0] words_sent;
`endif
    int vectors = 0, miscompares = 0;
    bit chk = 0;
    int m_t = 0, m_frames = 0, m_words = 0, cnt_offset = 0;
    logic [31:0] m_held = 0, m_word = 0;
    bit m_hfull = 0, m_isdata = 0, m_active = 0, m_out = 0, m_fs = 0;
    int isd_cycles = 0, isd_rises = 0;
    logic prev_isd = 0;
    always #5 clk_32f = ~clk_32f;
    lane_serializer dut (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .data_out(data_out), .frame_start(frame_start), .is_data(is_data)
`ifdef SER_WORD_CNT_EN
        , .words_sent(words_sent)
`endif
    );
    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask
    // model: frame position is simply (edges since reset) mod W
    always @(posedge clk_32f) begin : model
        bit acc;
        int pos;
        if (reset) begin
            m_t = 0; m_frames = 0; m_words = 0; m_hfull = 0; m_active = 0;
            m_out = 0; m_fs = 0; m_isdata = 0; m_word = 0;
        end else begin
            acc = valid_in && m_active && !m_hfull;
            pos = m_t % W;
            if (pos == 0) begin
                m_word = m_hfull ? m_held : IDLE;
                m_isdata = m_hfull;
                if (m_hfull) m_words++;
                m_hfull = 0;
                m_frames++;
                if (m_frames >= 4) m_active = 1;
            end
            m_out = m_word[W-1-pos];
            m_fs = (pos == 0);
            if (acc) begin
                m_held = data_in;
                m_hfull = 1;
            end
            m_t++;
        end
    end
    always @(negedge clk_32f) begin
        if (chk) begin
            check("data_out", 32'(data_out), 32'(m_out));
            check("frame_start", 32'(frame_start), 32'(m_fs));
            check("is_data", 32'(is_data), 32'(m_isdata));
            check("ready_out", 32'(ready_out), 32'(m_active && !m_hfull));
`ifdef SER_WORD_CNT_EN
            check("words_sent", 32'(words_sent), (cnt_offset + m_words > 65535) ? 65535 : cnt_offset + m_words);
`endif
        end
        if (is_data === 1) isd_cycles++;
        if (is_data === 1 && prev_isd !== 1) isd_rises++;
        prev_isd = is_data;
    end
    task automatic wait_ready();
        for (int i = 0; i < 200 && ready_out !== 1; i++) @(negedge clk_32f);
        if (ready_out !== 1) check("wait_ready_timeout", 32'(ready_out), 1);
    endtask
    task automatic send_word(input logic [31:0] w);
        wait_ready();
        data_in = w;
        valid_in = 1;
        @(negedge clk_32f);
        valid_in = 0;
    endtask
    task automatic wait_t(input int n);
        for (int i = 0; i < 400 && m_t < n; i++) @(negedge clk_32f);
        check("wait_t", m_t, n);
    endtask
    task automatic capture_frame(input bit want, output logic [31:0] w, output logic d);
        int i;
        w = '0;
        d = 0;
        for (i = 0; i < 200; i++) begin
            if (frame_start === 1 && (!want || is_data === 1)) break;
            @(negedge clk_32f);
        end
        if (i == 200) begin
            check("capture_timeout", 32'(frame_start), 1);
            return;
        end
        d = is_data;
        for (int b = W - 1; b >= 0; b--) begin
            w[b] = data_out;
            @(negedge clk_32f);
        end
    endtask
    initial begin
        logic [31:0] w;
        logic d;
        int s_cyc, s_rise, i;
        logic [31:0] stream [4] = '{32'h00000001, 32'h80000000, 32'hA5A5A5A5, 32'h0000FFFF};
        @(negedge clk_32f);
        chk = 1;
        repeat (2) @(negedge clk_32f);
        reset = 0;
        capture_frame(0, w, d);
        check("init_frame_word", w, IDLE);
        check("init_frame_isdata", 32'(d), 0);
        wait_t(96);
        check("ready_before_active", 32'(ready_out), 0);
        wait_t(97);
        check("ready_after_active", 32'(ready_out), 1);
        send_word(32'hDEADBEEF);
        check("ready_drop", 32'(ready_out), 0);
        capture_frame(1, w, d);
        check("deadbeef_word", w, 32'hDEADBEEF);
        check("deadbeef_isdata", 32'(d), 1);
        s_cyc = isd_cycles;
        s_rise = isd_rises;
        valid_in = 1;
        foreach (stream[k]) begin
            data_in = stream[k];
            wait_ready();
            @(negedge clk_32f);
        end
        valid_in = 0;
        repeat (3 * W) @(negedge clk_32f);
        check("stream_isdata_cycles", isd_cycles - s_cyc, 128);
        check("stream_bursts", isd_rises - s_rise, 1);
        for (i = 0; i < 200 && !(m_t % W == 0 && ready_out === 1); i++) @(negedge clk_32f);
        data_in = 32'h12345678;
        valid_in = 1;
        @(negedge clk_32f);
        valid_in = 0;
        capture_frame(0, w, d);
        check("load_edge_accept_idle", w, IDLE);
        check("load_edge_accept_idle_flag", 32'(d), 0);
        capture_frame(0, w, d);
        check("load_edge_accept_next", w, 32'h12345678);
        check("load_edge_accept_next_flag", 32'(d), 1);
        send_word(32'hCAFEF00D);
        send_word(32'h0BADC0DE);
        for (i = 0; i < 200 && !(m_isdata && (m_t - 1) % W == 10); i++) @(negedge clk_32f);
        reset = 1;
        @(negedge clk_32f);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_is_data", 32'(is_data), 0);
        check("rst_ready", 32'(ready_out), 0);
        reset = 0;
        s_cyc = isd_cycles;
        wait_t(96);
        check("rst_ready_before_active", 32'(ready_out), 0);
        wait_t(160);
        check("held_word_discarded", isd_cycles - s_cyc, 0);
`ifdef SER_WORD_CNT_EN
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        repeat (2 * W) @(negedge clk_32f);
        check("words_sent_3", 32'(words_sent), 3);
        cnt_offset = 65534 - m_words;
        force dut.words_sent = 16'hFFFE;
        #1 release dut.words_sent;
        send_word(32'h44444444);
        send_word(32'h55555555);
        repeat (2 * W) @(negedge clk_32f);
        check("words_sent_sat", 32'(words_sent), 32'h0000FFFF);
        send_word(32'h66666666);
        repeat (2 * W) @(negedge clk_32f);
        check("words_sent_stays", 32'(words_sent), 32'h0000FFFF);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
